mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter for the MIPS32 core. Instruction fetch and data load/store share one unified instruction/data memory. The block grants the memory to one requester at a time, sequences each access through a fixed read latency, and returns a one-cycle acknowledge with read data. It sits between the IF/MEM stage logic and the memory array, and its acknowledges are the stall source for both stages.

## Interface
- `ADDR_W`, 10, word address width (1024-word memory)
- `DATA_W`, 32, data word width
- `WAIT_CYC`, 1, memory synchronous read latency in cycles (≥1)
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (fairness build only)

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch word address
- `if_ack`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  DATA_W  fetch read data, valid with `if_ack`, held until next fetch ack
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  load data, valid with `d_ack`; unchanged by stores
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid WAIT_CYC cycles after the `mem_en` cycle
- `gnt_d`  out  1  high while the data port owns the current access
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: samples `if_req`/`d_req`. If neither is set, stays in IDLE. Otherwise latches the winner's address, we and wdata, and goes to ACCESS. The fetch port always uses we=0.
- Priority: data wins when both requests are high. This avoids deadlock, because the MEM stage holds older instructions.
- ACCESS lasts WAIT_CYC+1 cycles, counted by a wait counter.
  - `mem_en` is high only in the first ACCESS cycle.
  - `mem_addr`, `mem_we` and `mem_wdata` are held stable for the whole ACCESS.
  - A write is committed by the memory at the end of the first ACCESS cycle.
- At the edge leaving ACCESS, `mem_rdata` is captured into the granted port's rdata register (reads only), and the block goes to RESP.
- RESP: the granted port's ack is high for exactly one cycle. Next state is always IDLE. Requests are not sampled in RESP.
- Requester rule: `req`, `addr`, `we` and `wdata` stay stable from assertion until ack. At the edge ending the ack cycle, the requester either drops req or presents a new request, which IDLE samples.
- Reset: every output is 0, rdata registers are 0, counters are 0, state is IDLE.
- Reset mid-access abandons the access with no ack. A write whose `mem_en` cycle has already completed remains committed in memory.

## Timing
- Request sampled at the end of cycle 0:
  - `mem_en` high in cycle 1.
  - Ack high in cycle WAIT_CYC+2.
- Back-to-back accesses: one per WAIT_CYC+3 cycles (ACCESS + RESP + IDLE).
- All outputs are registered. There is no combinational path from `*_req` to `*_ack` or `mem_*`.
- `gnt_d` is valid from the first ACCESS cycle through RESP. It is 0 in IDLE.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A saturating `starve_cnt` increments on each data grant issued while `if_req` is high, and clears on each fetch grant.
  - When `starve_cnt` == STARVE_MAX in IDLE with both requests high, fetch wins and the counter clears.
- Undefined: strict data priority and no counter. Fetch waits as long as data keeps requesting.

## Test plan
- Fetch read, WAIT_CYC=1: memory preloaded with Mem[5]=32'hDEADBEEF; `if_req` with `if_addr`=5 sampled end of cycle 0 -> `mem_en`=1, `mem_addr`=5 in cycle 1; `if_ack`=1 with `if_rdata`=32'hDEADBEEF in cycle 3 only; `busy` high in cycles 1–3.
- Simultaneous requests: store `d_addr`=7, `d_wdata`=32'h1234 and fetch `if_addr`=7, both sampled cycle 0 -> `d_ack` in cycle 3, `gnt_d`=1 in cycles 1–3; fetch `mem_en` in cycle 5; `if_ack` in cycle 7 with `if_rdata`=32'h1234; `d_rdata` unchanged.
- Starvation, STARVE_MAX=4, `d_req` re-asserted every IDLE, `if_req` held -> with `MEM_ARB_FAIRNESS_EN`: fifth grant goes to fetch, then data resumes; without the macro: no `if_ack` until `d_req` drops.
- Reset mid-access: `rst` high in cycle 2 of a read -> in cycle 3 all outputs are 0 and state is IDLE; no ack ever appears for that request; a fresh request afterwards completes with normal latency.
- WAIT_CYC=3 load from Mem[9]=32'hCAFE0001 -> `mem_en` in cycle 1 only; `mem_addr`=9 in cycles 1–4; `d_ack` with `d_rdata`=32'hCAFE0001 in cycle 5.
- Back-to-back fetches of addresses 0, 1, 2 with WAIT_CYC=1 -> `if_ack` in cycles 3, 7, 11 with the matching data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one shared synchronous memory to the fetch or data port.
// Define MEM_ARB_FAIRNESS_EN to bound how many data grants may pass a waiting fetch.
module mem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WAIT_CYC   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              gnt_d,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshake: a requester raises req with stable addr/we/wdata and holds them
   // until its one-cycle ack; requests are only sampled while the FSM is IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int CNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              start, finish, grant_data, fetch_forced;

   logic              gnt_d_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              if_ack_q, d_ack_q, busy_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

   assign fetch_forced = if_req && d_req && (starve_cnt_q == STARVE_LIM);

   // Counts data grants that overtook a pending fetch; any fetch grant clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (start) begin
         if (!grant_data) begin
            starve_cnt_d = '0;
         end else if (if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign fetch_forced = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      start      = 1'b0;
      finish     = 1'b0;
      grant_data = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               start      = 1'b1;
               grant_data = d_req && !fetch_forced;
               wait_cnt_d = '0;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (wait_cnt_q == CNT_LAST) begin
               finish     = 1'b1;
               wait_cnt_d = '0;
               state_d    = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // All outputs come from registers loaded off the next-state decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_d_q    <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         busy_q     <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         mem_en_q <= start;
         busy_q   <= (state_d != IDLE);
         if_ack_q <= finish && !gnt_d_q;
         d_ack_q  <= finish && gnt_d_q;
         if (start) begin
            gnt_d_q  <= grant_data;
            mem_we_q <= grant_data && d_we;
            addr_q   <= grant_data ? d_addr : if_addr;
            wdata_q  <= grant_data ? d_wdata : '0;
         end
         if (finish) begin
            mem_we_q <= 1'b0;
            if (!mem_we_q) begin
               if (gnt_d_q) begin
                  d_rdata_q <= mem_rdata;
               end else begin
                  if_rdata_q <= mem_rdata;
               end
            end
         end
         if (state_q == RESP) begin
            gnt_d_q <= 1'b0;
         end
      end
   end

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign gnt_d     = gnt_d_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random transactions against a
// transaction-level model; a second instance covers a three-cycle memory.
module tb_mem_port_arbiter;

   localparam int W = 1;
`ifdef MEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic preload = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT (WAIT_CYC = 1) ----------------
   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [9:0]  if_addr = '0, d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        if_ack, d_ack, mem_en, mem_we, gnt_d, busy;
   logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [9:0]  mem_addr;
   logic [1:0]  dbg_state;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(W), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .gnt_d(gnt_d), .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- DUT (WAIT_CYC = 3) ----------------
   logic        if3_req = 0, d3_req = 0, d3_we = 0;
   logic [9:0]  if3_addr = '0, d3_addr = '0;
   logic [31:0] d3_wdata = '0;
   logic        if3_ack, d3_ack, m3_en, m3_we, g3, b3;
   logic [31:0] if3_rdata, d3_rdata, m3_wdata, m3_rdata;
   logic [9:0]  m3_addr;
   logic [1:0]  s3;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if3_req), .if_addr(if3_addr), .if_ack(if3_ack), .if_rdata(if3_rdata),
      .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
      .d_ack(d3_ack), .d_rdata(d3_rdata),
      .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
      .mem_rdata(m3_rdata), .gnt_d(g3), .busy(b3), .dbg_state(s3)
   );

   // ---------------- memory arrays (junk when no read was issued) ----------------
   logic [31:0] seed = 32'h0;
   logic [31:0] mem_arr [1024];
   logic [31:0] rd_s0 = 32'hBAD0BAD0;
   logic [31:0] r3_0 = 32'hBAD0BAD0, r3_1 = 32'hBAD0BAD0, r3_2 = 32'hBAD0BAD0;

   function automatic logic [31:0] init_val(input int a);
      case (a)
         5:       return 32'hDEADBEEF;
         9:       return 32'hCAFE0001;
         default: return (32'(a) * 32'h9E3779B9) ^ seed;
      endcase
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= init_val(i);
      end else if (mem_en && mem_we) begin
         mem_arr[mem_addr] <= mem_wdata;
      end
      rd_s0 <= mem_en ? mem_arr[mem_addr] : 32'hBAD0BAD0;
      r3_0  <= m3_en ? init_val(int'(m3_addr)) : 32'hBAD0BAD0;
      r3_1  <= r3_0;
      r3_2  <= r3_1;
   end
   assign mem_rdata = rd_s0;
   assign m3_rdata  = r3_2;

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] model_mem [1024];
   logic [31:0] exp_q [$];
   logic [31:0] d_hold = '0, if_hold = '0;
   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit in_win(input int c, input int s, input int len);
      return (s > 0) && (c >= s) && (c < s + len);
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_if_ack"}, if_ack, 0);
      chk({tag, "_d_ack"}, d_ack, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_gnt_d"}, gnt_d, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_state"}, dbg_state, 0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      if_req = 0;
      d_req = 0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      d_hold = '0;
      if_hold = '0;
      exp_q.delete();
   endtask

   // ---------------- driver: one fetch and/or data transaction ----------------
   // Data wins a tie, so its access starts at cycle 1 and the fetch follows
   // after the data RESP and one IDLE cycle.
   task automatic xact(input bit do_if, input bit do_d, input bit we,
                       input logic [9:0] ia, input logic [9:0] da, input logic [31:0] wd);
      int sd, si, ad, ai, last;
      tick();
      chk("idle_busy", busy, 0);
      sd = do_d ? 1 : -100;
      si = !do_if ? -100 : (do_d ? W + 4 : 1);
      ad = sd + W + 1;
      ai = si + W + 1;
      last = do_if ? ai : ad;
      if (do_d) begin
         if (we) model_mem[da] = wd;
         else d_hold = model_mem[da];
         exp_q.push_back(d_hold);
      end
      if (do_if) begin
         if_hold = model_mem[ia];
         exp_q.push_back(if_hold);
      end
      if_req = do_if; if_addr = ia;
      d_req = do_d; d_we = we; d_addr = da; d_wdata = wd;
      for (int c = 1; c <= last; c++) begin
         tick();
         chk("mem_en", mem_en, 32'((c == sd) || (c == si)));
         chk("busy", busy, 32'(in_win(c, sd, W + 2) || in_win(c, si, W + 2)));
         chk("gnt_d", gnt_d, 32'(in_win(c, sd, W + 2)));
         chk("d_ack", d_ack, 32'(c == ad));
         chk("if_ack", if_ack, 32'(c == ai));
         if (in_win(c, sd, W + 1)) begin
            chk("d_mem_addr", mem_addr, da);
            chk("d_mem_we", mem_we, we);
            if (we) chk("d_mem_wdata", mem_wdata, wd);
         end
         if (in_win(c, si, W + 1)) begin
            chk("if_mem_addr", mem_addr, ia);
            chk("if_mem_we", mem_we, 0);
         end
         if (c == ad) begin
            chk("d_rdata", d_rdata, exp_q.pop_front());
            d_req = 0;
         end
         if (c == ai) begin
            chk("if_rdata", if_rdata, exp_q.pop_front());
            if_req = 0;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int g, nd, c, kind;
      logic [31:0] exp_d_cur;
      seed = $urandom;
      tick();
      preload = 1'b0;
      for (int i = 0; i < 1024; i++) model_mem[i] = init_val(i);
      reset_dut();

      // fetch read of Mem[5]
      xact(1, 0, 0, 10'd5, 10'd0, 32'h0);
      chk("fetch5_data", if_rdata, 32'hDEADBEEF);

      // simultaneous store and fetch to address 7
      xact(1, 1, 1, 10'd7, 10'd7, 32'h1234);
      chk("store_then_fetch", if_rdata, 32'h1234);
      chk("d_rdata_kept", d_rdata, 32'h0);

      // back-to-back fetches
      for (int a = 0; a < 3; a++) xact(1, 0, 0, 10'(a), 10'd0, 32'h0);

      // random mix
      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 3);
         xact(kind == 0 || kind == 3, kind != 0, (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1),
              10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)), $urandom);
      end

      // starvation: data re-requests every IDLE while fetch waits
      reset_dut();
      tick();
      if_req = 1; if_addr = 10'd3;
      d_req = 1; d_we = 0; d_addr = 10'($urandom_range(16, 31));
      exp_d_cur = model_mem[d_addr];
      g = 0; nd = 0; c = 0;
      while (g < (FAIR ? 6 : 7) && c < 60) begin
         tick();
         c++;
         if (d_ack || if_ack) begin
            chk("starve_ack_cycle", c, 3 + 4 * g);
            chk("starve_ack_port", if_ack, 32'(g == (FAIR ? 4 : 6)));
            if (d_ack) begin
               chk("starve_d_rdata", d_rdata, exp_d_cur);
               nd++;
               if (nd == 6) d_req = 0;
               else begin
                  d_addr = 10'($urandom_range(16, 31));
                  exp_d_cur = model_mem[d_addr];
               end
            end
            if (if_ack) begin
               chk("starve_if_rdata", if_rdata, model_mem[3]);
               if_req = 0;
            end
            g++;
         end
      end
      chk("starve_grants", g, FAIR ? 6 : 7);
      d_req = 0;
      if_req = 0;

      // reset in the middle of a fetch read
      reset_dut();
      xact(1, 0, 0, 10'd9, 10'd0, 32'h0);
      tick();
      if_req = 1; if_addr = 10'd5;
      tick();
      chk("rst_mid_mem_en", mem_en, 1);
      tick();
      rst = 1; if_req = 0;
      tick();
      rst = 0;
      chk_reset_outputs("rst_mid");
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rst_no_ack", if_ack, 0);
         chk("rst_no_mem_en", mem_en, 0);
      end
      if_hold = '0;
      xact(1, 0, 0, 10'd5, 10'd0, 32'h0);

      // three-cycle memory load from Mem[9]
      tick();
      d3_req = 1; d3_addr = 10'd9;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("w3_mem_en", m3_en, 32'(k == 1));
         chk("w3_busy", b3, 32'(k <= 5));
         if (k <= 4) chk("w3_mem_addr", m3_addr, 10'd9);
         chk("w3_d_ack", d3_ack, 32'(k == 5));
         if (k == 5) begin
            chk("w3_d_rdata", d3_rdata, 32'hCAFE0001);
            d3_req = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
